// File: rtl/ex_div.sv
// ---------------------------------------------------------------------------
// ex_div -- multi-cycle 32-bit integer divider for the execute stage.
//
// Takes the DIV/DIVU operands that the ID/EX register hands to EX and, after
// a fixed number of cycles, returns {remainder, quotient}. One restoring
// division step runs per clock. Both outputs come straight from registers.
//
// Ports
//   clk           in   1   clock, all state changes on the rising edge
//   rst           in   1   synchronous active-high reset
//   signed_div_i  in   1   1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     in  32   dividend
//   opdata2_i     in  32   divisor
//   start_i       in   1   divide request, held by EX until ready_o seen
//   annul_i       in   1   abort an in-flight divide (branch / flush)
//   result_o      out 64   {remainder[63:32], quotient[31:0]}
//   ready_o       out  1   result_o is valid
//
// Handshake: EX raises start_i together with the operands and keeps it high
// (operands may change freely after the start edge, they are latched). The
// divider raises ready_o with result_o and holds both for as long as
// start_i stays high. Dropping start_i returns the divider to idle on the
// next edge, clearing ready_o and result_o; a new request is accepted only
// after that idle edge. annul_i kills a running divide without a result and
// blocks acceptance of a new start while idle.
// ---------------------------------------------------------------------------
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;        // completed iteration count, 0..32
  logic [64:0] work_q;       // {partial remainder, dividend/quotient}
  logic [31:0] divisor_q;    // magnitude of the divisor
  logic        signed_q;     // latched signed_div_i
  logic        sign1_q;      // latched dividend sign bit
  logic        sign2_q;      // latched divisor sign bit
  logic [63:0] result_q;
  logic        ready_q;

  // Operand magnitudes for the start edge. Only signed ops with a negative
  // operand are negated; INT_MIN negates to itself, which is its correct
  // unsigned magnitude.
  logic [31:0] op1_abs_d;
  logic [31:0] op2_abs_d;

  always_comb begin
    op1_abs_d = opdata1_i;
    op2_abs_d = opdata2_i;
    if (signed_div_i && opdata1_i[31]) op1_abs_d = ~opdata1_i + 32'd1;
    if (signed_div_i && opdata2_i[31]) op2_abs_d = ~opdata2_i + 32'd1;
  end

  // One restoring step. The working register is shifted left into a 66-bit
  // view so the trial subtraction sees the full 34-bit upper slice; bit 33
  // of the difference is the borrow, i.e. "partial remainder < divisor".
  logic [65:0] shifted_d;
  logic [33:0] diff_d;
  logic [64:0] step_d;

  always_comb begin
    shifted_d = {work_q, 1'b0};
    diff_d    = shifted_d[65:32] - {2'b00, divisor_q};
    if (!diff_d[33]) begin
      step_d = {diff_d[32:0], shifted_d[31:1], 1'b1};
    end else begin
      step_d = shifted_d[64:0];
    end
  end

  // Sign fix-up applied when the result is loaded. The quotient is negative
  // when the operand signs differ; the remainder follows the dividend sign.
  logic [31:0] quot_raw_d;
  logic [31:0] rem_raw_d;
  logic [31:0] quot_fix_d;
  logic [31:0] rem_fix_d;

  always_comb begin
    quot_raw_d = work_q[31:0];
    rem_raw_d  = work_q[63:32];
    quot_fix_d = quot_raw_d;
    rem_fix_d  = rem_raw_d;
    if (signed_q && (sign1_q ^ sign2_q)) quot_fix_d = ~quot_raw_d + 32'd1;
    if (signed_q && sign1_q)             rem_fix_d  = ~rem_raw_d + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= 64'd0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state_q <= S_BYZERO;
            end else begin
              state_q   <= S_ON;
              cnt_q     <= 6'd0;
              work_q    <= {33'd0, op1_abs_d};
              divisor_q <= op2_abs_d;
              signed_q  <= signed_div_i;
              sign1_q   <= opdata1_i[31];
              sign2_q   <= opdata2_i[31];
            end
          end
        end

        // Division by zero produces a zero result one edge later.
        S_BYZERO: begin
          state_q  <= S_END;
          result_q <= 64'd0;
          ready_q  <= 1'b1;
        end

        S_ON: begin
          if (annul_i) begin
            // Annul takes priority over the final (counter == 32) edge.
            state_q  <= S_FREE;
            cnt_q    <= 6'd0;
            ready_q  <= 1'b0;
            result_q <= 64'd0;
          end else if (cnt_q == 6'd32) begin
            state_q  <= S_END;
            result_q <= {rem_fix_d, quot_fix_d};
            ready_q  <= 1'b1;
          end else begin
            work_q <= step_d;
            cnt_q  <= cnt_q + 6'd1;
          end
        end

        // Hold the result until EX drops its request.
        S_END: begin
          if (!start_i) begin
            state_q  <= S_FREE;
            ready_q  <= 1'b0;
            result_q <= 64'd0;
          end
        end

        default: begin
          state_q  <= S_FREE;
          ready_q  <= 1'b0;
          result_q <= 64'd0;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// ---------------------------------------------------------------------------
// tb_ex_div -- self-checking bench for ex_div. Expected results are pushed to
// exp_q when a divide is started and popped when ready_o rises.
// ---------------------------------------------------------------------------
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return 64'd0;
    ua = (sgn && a[31]) ? (32'd0 - a) : a;
    ub = (sgn && b[31]) ? (32'd0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sgn && (a[31] != b[31])) q = 32'd0 - q;
    if (sgn && a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // Counts edges from the next one (E0) until ready_o rises, checks the
  // latency and compares result_o against the head of the scoreboard.
  task automatic wait_ready(input int exp_lat, input string name);
    int n = 0;
    logic [63:0] exp;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ready_o === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, n, exp_lat);
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: queue empty at ready", name);
    end else begin
      exp = exp_q.pop_front();
      if (n != 0) begin
        checks++;
        if (result_o !== exp) begin
          errors++;
          $display("FAIL %s result: got %h, expected %h", name, result_o, exp);
        end
      end
    end
  endtask

  task automatic release_start(input string name);
    start_i = 1'b0;
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL %s release: ready=%b result=%h, expected ready=0 result=0",
               name, ready_o, result_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    repeat (3) tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset: ready=%b result=%h, expected 0/0", ready_o, result_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    start_div(1'b0, 32'd100, 32'd7);
    exp_q.push_back({32'h00000002, 32'h0000000E});
    wait_ready(34, "unsigned_100_7");
    tick();
    checks++;
    if (ready_o !== 1'b1 || result_o !== {32'h00000002, 32'h0000000E}) begin
      errors++;
      $display("FAIL hold_end: ready=%b result=%h, expected 1/%h", ready_o, result_o,
               {32'h00000002, 32'h0000000E});
    end
    release_start("unsigned_100_7");
  endtask

  task automatic test_signed();
    start_div(1'b1, 32'hFFFFFFF9, 32'd2);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    wait_ready(34, "signed_m7_2");
    release_start("signed_m7_2");
    start_div(1'b1, 32'd7, 32'hFFFFFFFE);
    exp_q.push_back({32'h00000001, 32'hFFFFFFFD});
    wait_ready(34, "signed_7_m2");
    release_start("signed_7_m2");
  endtask

  task automatic test_div_zero();
    start_div(1'b1, 32'h12345678, 32'd0);
    exp_q.push_back(64'd0);
    wait_ready(2, "divzero_signed");
    release_start("divzero_signed");
    start_div(1'b0, 32'h12345678, 32'd0);
    exp_q.push_back(64'd0);
    wait_ready(2, "divzero_unsigned");
    release_start("divzero_unsigned");
  endtask

  task automatic test_annul();
    logic seen = 1'b0;
    start_div(1'b0, 32'd1234, 32'd5);
    tick();                       // E0
    repeat (9) tick();            // E1..E9
    annul_i = 1'b1;
    tick();                       // E10 annulled
    annul_i = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL annul_mid: ready rose=%b, expected never", seen);
    end
    start_div(1'b0, 32'hFFFFFFFF, 32'h10);
    exp_q.push_back({32'h0000000F, 32'h0FFFFFFF});
    wait_ready(34, "after_annul");
    release_start("after_annul");
  endtask

  task automatic test_annul_last_edge();
    start_div(1'b0, 32'd500, 32'd3);
    tick();                       // E0
    repeat (32) tick();           // E1..E32
    annul_i = 1'b1;
    tick();                       // E33 with annul
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL annul_last: ready=%b result=%h, expected 0/0", ready_o, result_o);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL annul_last_after: ready=%b, expected 0", ready_o);
    end
  endtask

  task automatic test_annul_free();
    annul_i = 1'b1;
    start_div(1'b0, 32'd1000, 32'd10);
    repeat (5) tick();
    // Annul is released with start still high: that edge is E0.
    annul_i = 1'b0;
    exp_q.push_back(model_div(1'b0, 32'd1000, 32'd10));
    wait_ready(34, "annul_free");
    release_start("annul_free");
  endtask

  task automatic test_reset_mid();
    start_div(1'b0, 32'hDEADBEEF, 32'h1234);
    exp_q.push_back(model_div(1'b0, 32'hDEADBEEF, 32'h1234));
    tick();                       // E0
    repeat (19) tick();           // E1..E19
    rst = 1'b1;
    tick();                       // E20 with reset
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b result=%h, expected 0/0", ready_o, result_o);
    end
    rst = 1'b0;
    wait_ready(34, "reset_restart");
    release_start("reset_restart");
  endtask

  task automatic test_int_min_toggle();
    int n = 0;
    start_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
    tick();                       // E0
    for (int i = 2; i <= 60; i++) begin
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
      tick();
      if (ready_o === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 34) begin
      errors++;
      $display("FAIL int_min latency: got %0d edges, expected 34", n);
    end
    checks++;
    if (result_o !== {32'h00000000, 32'h80000000}) begin
      errors++;
      $display("FAIL int_min result: got %h, expected %h", result_o,
               {32'h00000000, 32'h80000000});
    end
    release_start("int_min");
  endtask

  task automatic test_back_to_back();
    logic        sgn;
    logic [31:0] a, b;
    for (int k = 0; k < 10; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      if (k == 1) b = 32'd0;
      start_div(sgn, a, b);
      exp_q.push_back(model_div(sgn, a, b));
      wait_ready((b == 32'd0) ? 2 : 34, "back_to_back");
      release_start("back_to_back");
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_annul_last_edge();
    test_annul_free();
    test_reset_mid();
    test_int_min_toggle();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
